// File: rtl/control_cmd_serializer.sv
// Serializes one parallel control command into the opcode/block/reg/data/instr
// byte stream consumed by control_unit_seq, with an inter-byte gap and a per-byte ack timeout.
module control_cmd_serializer #(
    parameter int n_blocks       = 32,
    parameter int reg_addr_width = 4,
    parameter int data_width     = 16,
    parameter int instr_width    = 32,
    parameter int gap_cycles     = 1,
    parameter int timeout_cycles = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_opcode,
    input  logic                          cmd_has_block,
    input  logic                          cmd_has_reg,
    input  logic                          cmd_has_data,
    input  logic                          cmd_has_instr,
    input  logic [$clog2(n_blocks)-1:0]   cmd_block,
    input  logic [reg_addr_width-1:0]     cmd_reg,
    input  logic [data_width-1:0]         cmd_data,
    input  logic [instr_width-1:0]        cmd_instr,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_next,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout
);

    // state  | meaning
    // IDLE   | waiting for a command (cmd_ready once the gap has expired)
    // OPCODE | presenting the opcode byte
    // BLOCK  | presenting the block number byte
    // REG    | presenting the register number byte
    // DATA   | presenting data bytes, MSB first
    // INSTR  | presenting instruction bytes, MSB first
    // GAP    | out_valid low between bytes; pend_state holds the next field
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OPCODE = 3'd1;
    localparam logic [2:0] BLOCK  = 3'd2;
    localparam logic [2:0] REG    = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] INSTR  = 3'd5;
    localparam logic [2:0] GAP    = 3'd6;

    localparam int blk_w = $clog2(n_blocks);
    localparam int db    = data_width / 8;
    localparam int ib    = instr_width / 8;
    localparam int bc_w  = $clog2(((db > ib) ? db : ib) + 1);
    localparam int gap_w = (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
    localparam int to_w  = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;

    localparam logic [gap_w-1:0] gap_load = gap_w'(gap_cycles);
    localparam logic [to_w-1:0]  to_last  = to_w'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

    logic [2:0]                state;
    logic [2:0]                pend_state;
    logic [2:0]                next_field;
    logic [2:0]                after_op;
    logic [2:0]                after_block;
    logic [2:0]                after_reg;
    logic [2:0]                after_data;
    logic [7:0]                op_q;
    logic [blk_w-1:0]          blk_q;
    logic [reg_addr_width-1:0] reg_q;
    logic [data_width-1:0]     data_sr;
    logic [instr_width-1:0]    instr_sr;
    logic                      has_block_q;
    logic                      has_reg_q;
    logic                      has_data_q;
    logic                      has_instr_q;
    logic [bc_w-1:0]           byte_cnt;
    logic [gap_w-1:0]          gap_cnt;
    logic [to_w-1:0]           to_cnt;
    logic                      accept;
    logic                      expire;
    logic                      more_bytes;

    assign cmd_ready  = (state == IDLE) && (gap_cnt == '0);
    assign busy       = (state != IDLE);
    assign accept     = out_valid && out_next;
    assign expire     = (timeout_cycles != 0) && out_valid && !out_next && (to_cnt == to_last);
    assign more_bytes = (byte_cnt != '0);

    // Field order is fixed; each stage falls through to the next flagged field.
    always_comb begin
        after_data  = has_instr_q ? INSTR : IDLE;
        after_reg   = has_data_q  ? DATA  : after_data;
        after_block = has_reg_q   ? REG   : after_reg;
        after_op    = has_block_q ? BLOCK : after_block;
        next_field  = IDLE;
        case (state)
            OPCODE:  next_field = after_op;
            BLOCK:   next_field = after_block;
            REG:     next_field = after_reg;
            DATA:    next_field = more_bytes ? DATA : after_data;
            INSTR:   next_field = more_bytes ? INSTR : IDLE;
            default: next_field = IDLE;
        endcase
    end

    always_comb begin
        out_byte = '0;
        case (state)
            OPCODE:  out_byte = op_q;
            BLOCK:   out_byte = 8'(blk_q);
            REG:     out_byte = 8'(reg_q);
            DATA:    out_byte = data_sr[data_width-1 -: 8];
            INSTR:   out_byte = instr_sr[instr_width-1 -: 8];
            default: out_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pend_state  <= IDLE;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            gap_cnt     <= gap_load;
            to_cnt      <= '0;
            byte_cnt    <= '0;
            op_q        <= '0;
            blk_q       <= '0;
            reg_q       <= '0;
            data_sr     <= '0;
            instr_sr    <= '0;
            has_block_q <= 1'b0;
            has_reg_q   <= 1'b0;
            has_data_q  <= 1'b0;
            has_instr_q <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    op_q        <= cmd_opcode;
                    blk_q       <= cmd_block;
                    reg_q       <= cmd_reg;
                    data_sr     <= cmd_data;
                    instr_sr    <= cmd_instr;
                    has_block_q <= cmd_has_block;
                    has_reg_q   <= cmd_has_reg;
                    has_data_q  <= cmd_has_data;
                    has_instr_q <= cmd_has_instr;
                    to_cnt      <= '0;
                    out_valid   <= 1'b1;
                    state       <= OPCODE;
                end
            end else if (state == GAP) begin
                if (gap_cnt <= gap_w'(1)) begin
                    state     <= pend_state;
                    out_valid <= 1'b1;
                end
            end else if (accept) begin
                to_cnt <= '0;
                if (state == DATA) begin
                    data_sr <= data_sr << 8;
                end
                if (state == INSTR) begin
                    instr_sr <= instr_sr << 8;
                end
                if (next_field == DATA && state != DATA) begin
                    byte_cnt <= bc_w'(db - 1);
                end else if (next_field == INSTR && state != INSTR) begin
                    byte_cnt <= bc_w'(ib - 1);
                end else if (more_bytes) begin
                    byte_cnt <= byte_cnt - 1'b1;
                end
                if (next_field == IDLE) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                    gap_cnt   <= gap_load;
                end else if (gap_cycles == 0) begin
                    state <= next_field;
                end else begin
                    state      <= GAP;
                    pend_state <= next_field;
                    out_valid  <= 1'b0;
                    gap_cnt    <= gap_load;
                end
            end else if (expire) begin
                // Abandon the rest of the command; the gap still applies before the next one.
                state     <= IDLE;
                out_valid <= 1'b0;
                timeout   <= 1'b1;
                to_cnt    <= '0;
                gap_cnt   <= gap_load;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule
